// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM arbiter: FSM states, default widths and
// the request record used to describe one RAM access.
package ram_arb_pkg;

    localparam int DEFAULT_ADDR_W = 12;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        READ_RSP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                      we;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on contention
// the side named by ptr wins, and the pointer then favours the loser.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_next
);

    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        // ptr = 0 favours m0, ptr = 1 favours m1
        if (gnt[0]) begin
            ptr_next = 1'b1;
        end else if (gnt[1]) begin
            ptr_next = 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port data RAM between two requesters: accepts one request
// at a time, strobes the RAM for one cycle and steers read data to its owner.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_input,
    output logic              ram_store,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_data_output
);

    arb_state_t        state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic              owner_reg, owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic [1:0]        req_vec;
    logic [1:0]        pick_gnt;
    logic              pick_ptr_next;
    logic [1:0]        gnt_vec;
    logic [1:0]        rvalid_vec;
    logic [DATA_W-1:0] rdata_arr [2];

    assign req_vec = {m1_req, m0_req};

    rr_arb2 u_pick (
        .req      (req_vec),
        .ptr      (ptr_reg),
        .gnt      (pick_gnt),
        .ptr_next (pick_ptr_next)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        gnt_vec    = 2'b00;
        case (state_reg)
            IDLE: begin
                // A grant during reset would be lost at the edge, so hold it off
                if (!rst && (|req_vec)) begin
                    gnt_vec    = pick_gnt;
                    ptr_next   = pick_ptr_next;
                    owner_next = pick_gnt[1];
                    if (pick_gnt[1]) begin
                        we_next    = m1_we;
                        addr_next  = m1_addr;
                        wdata_next = m1_wdata;
                    end else begin
                        we_next    = m0_we;
                        addr_next  = m0_addr;
                        wdata_next = m0_wdata;
                    end
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = we_reg ? IDLE : READ_RSP;
            end
            READ_RSP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Address/data simply mirror the latched request; only the strobes qualify them
    assign ram_address    = addr_reg;
    assign ram_data_input = wdata_reg;
    assign ram_store      = (state_reg == ACCESS) && we_reg;
    assign ram_load       = (state_reg == ACCESS) && !we_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign rvalid_vec[gi] = (state_reg == READ_RSP) && (owner_reg == 1'(gi));
            assign rdata_arr[gi]  = rvalid_vec[gi] ? ram_data_output : '0;
        end
    endgenerate

    assign m0_gnt    = gnt_vec[0];
    assign m1_gnt    = gnt_vec[1];
    assign m0_rvalid = rvalid_vec[0];
    assign m1_rvalid = rvalid_vec[1];
    assign m0_rdata  = rdata_arr[0];
    assign m1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus
// random traffic checked every cycle against a cycle-count based model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [11:0] m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [11:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [11:0] ram_address;
    logic [31:0] ram_data_input;
    logic        ram_store, ram_load;
    logic [31:0] ram_data_output = '0;

    int tests = 0;
    int fails = 0;

    ram_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .m0_req          (m0_req),
        .m0_we           (m0_we),
        .m0_addr         (m0_addr),
        .m0_wdata        (m0_wdata),
        .m0_gnt          (m0_gnt),
        .m0_rvalid       (m0_rvalid),
        .m0_rdata        (m0_rdata),
        .m1_req          (m1_req),
        .m1_we           (m1_we),
        .m1_addr         (m1_addr),
        .m1_wdata        (m1_wdata),
        .m1_gnt          (m1_gnt),
        .m1_rvalid       (m1_rvalid),
        .m1_rdata        (m1_rdata),
        .ram_address     (ram_address),
        .ram_data_input  (ram_data_input),
        .ram_store       (ram_store),
        .ram_load        (ram_load),
        .ram_data_output (ram_data_output)
    );

    always #5 clk = ~clk;

    // The RAM the arbiter fronts: write on store edge, registered read on load edge
    logic [31:0] ram_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
    end
    always @(posedge clk) begin
        if (ram_store) ram_mem[ram_address] <= ram_data_input;
        if (ram_load)  ram_data_output <= ram_mem[ram_address];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request is taken on the first cycle at or after free_cyc; the strobe
    // follows one cycle later and read data two cycles later.
    int          cyc = 0, free_cyc = 0, t_acc = -10, t_rsp = -10;
    int          model_grants = 0;
    int          m_w;
    bit          fav = 1'b0, mdl_on = 1'b0;
    bit          acc_we, rsp_owner;
    logic [11:0] acc_addr;
    logic [31:0] acc_wdata, rsp_data;
    bit [1:0]    e_gnt, e_rv;
    bit          e_st, e_ld;
    logic [31:0] e_rd0, e_rd1;

    always @(negedge clk) begin
        e_gnt = '0;
        m_w   = -1;
        if (!rst && cyc >= free_cyc && (m0_req || m1_req)) begin
            m_w = (m0_req && m1_req) ? int'(fav) : (m1_req ? 1 : 0);
            e_gnt[m_w] = 1'b1;
        end
        e_st  = (cyc == t_acc) && acc_we;
        e_ld  = (cyc == t_acc) && !acc_we;
        e_rv  = '0;
        e_rd0 = '0;
        e_rd1 = '0;
        if (cyc == t_rsp) begin
            e_rv[rsp_owner] = 1'b1;
            if (rsp_owner) e_rd1 = rsp_data;
            else           e_rd0 = rsp_data;
        end
        if (mdl_on) begin
            chk("m0_gnt", m0_gnt, e_gnt[0]);
            chk("m1_gnt", m1_gnt, e_gnt[1]);
            chk("ram_store", ram_store, e_st);
            chk("ram_load", ram_load, e_ld);
            chk("store_load_excl", ram_store & ram_load, 0);
            chk("m0_rvalid", m0_rvalid, e_rv[0]);
            chk("m1_rvalid", m1_rvalid, e_rv[1]);
            chk("m0_rdata", m0_rdata, e_rd0);
            chk("m1_rdata", m1_rdata, e_rd1);
            if (cyc == t_acc) begin
                chk("ram_address", ram_address, acc_addr);
                chk("ram_data_input", ram_data_input, acc_wdata);
            end
        end
        if (rst) begin
            mdl_on   = 1'b1;
            free_cyc = cyc + 1;
            fav      = 1'b0;
            t_rsp    = -10;
            if (t_acc > cyc) t_acc = -10;
        end else if (m_w >= 0) begin
            model_grants++;
            fav       = (m_w == 0);
            acc_we    = (m_w == 1) ? m1_we    : m0_we;
            acc_addr  = (m_w == 1) ? m1_addr  : m0_addr;
            acc_wdata = (m_w == 1) ? m1_wdata : m0_wdata;
            t_acc     = cyc + 1;
            if (acc_we) begin
                ref_mem[acc_addr] = acc_wdata;
                free_cyc = cyc + 2;
            end else begin
                rsp_data  = ref_mem[acc_addr];
                rsp_owner = (m_w == 1);
                t_rsp     = cyc + 2;
                free_cyc  = cyc + 3;
            end
            $display("[TB] cyc %0d grant m%0d %s addr=%03h data=%08h", cyc, m_w,
                     acc_we ? "WR" : "RD", acc_addr, acc_we ? acc_wdata : rsp_data);
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit on, input mem_req_t r);
        if (p == 0) begin
            m0_req = on; m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata;
        end else begin
            m1_req = on; m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata;
        end
    endtask

    // Raise a request, wait (bounded) for its grant, then release it
    task automatic issue(input int p, input mem_req_t r);
        bit ok = 1'b0;
        set_req(p, 1'b1, r);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((p == 0) ? m0_gnt : m1_gnt) ok = 1'b1;
        end
        chk("grant_timeout", ok, 1'b1);
        step();
        set_req(p, 1'b0, r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_req_t r;
        int got[$];
        int gcyc[$];
        int base;
        bit ok;

        step(); step(); step();
        rst = 1'b0;
        chk("rst_ram_store", ram_store, 0);
        chk("rst_ram_address", ram_address, 0);

        // 1: m0 write
        r = '{we: 1'b1, addr: 12'h005, wdata: 32'hABCDEF01};
        set_req(0, 1'b1, r);
        @(negedge clk); chk("t1_gnt", m0_gnt, 1); chk("t1_m1_gnt", m1_gnt, 0);
        step(); m0_req = 1'b0;
        @(negedge clk); chk("t1_store", ram_store, 1); chk("t1_load", ram_load, 0);
        chk("t1_addr", ram_address, 12'h005); chk("t1_din", ram_data_input, 32'hABCDEF01);
        step();
        @(negedge clk); chk("t1_idle_store", ram_store, 0); chk("t1_idle_gnt", m0_gnt, 0);
        step();

        // 2: m0 read back
        r = '{we: 1'b0, addr: 12'h005, wdata: 32'h0};
        set_req(0, 1'b1, r);
        @(negedge clk); chk("t2_gnt", m0_gnt, 1);
        step(); m0_req = 1'b0;
        @(negedge clk); chk("t2_load", ram_load, 1); chk("t2_early_rvalid", m0_rvalid, 0);
        step();
        @(negedge clk); chk("t2_rvalid", m0_rvalid, 1); chk("t2_rdata", m0_rdata, 32'hABCDEF01);
        chk("t2_m1_rvalid", m1_rvalid, 0); chk("t2_m1_rdata", m1_rdata, 0);
        step();

        // 3: contention from reset alternates m0,m1,m0,m1
        do_reset();
        set_req(0, 1'b1, '{we: 1'b0, addr: 12'h010, wdata: 32'h0});
        set_req(1, 1'b1, '{we: 1'b0, addr: 12'h020, wdata: 32'h0});
        for (int i = 0; i < 30 && got.size() < 4; i++) begin
            @(negedge clk);
            if (m0_gnt) got.push_back(0);
            if (m1_gnt) got.push_back(1);
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t3_grant_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("t3_order", got[i], i % 2);
        repeat (4) step();

        // 4: m1 alone gets every free cycle (writes: one grant every 2 cycles)
        set_req(1, 1'b1, '{we: 1'b1, addr: 12'h030, wdata: 32'h5A5A0001});
        for (int i = 0; i < 20 && gcyc.size() < 3; i++) begin
            @(negedge clk);
            if (m1_gnt) gcyc.push_back(i);
            chk("t4_m0_gnt", m0_gnt, 0);
            step();
        end
        m1_req = 1'b0;
        chk("t4_grants", gcyc.size(), 3);
        if (gcyc.size() == 3) begin
            chk("t4_first", gcyc[0], 0);
            chk("t4_gap1", gcyc[1] - gcyc[0], 2);
            chk("t4_gap2", gcyc[2] - gcyc[1], 2);
        end
        repeat (3) step();

        // 5: reset during the ACCESS cycle of a read
        set_req(0, 1'b1, '{we: 1'b0, addr: 12'h005, wdata: 32'h0});
        @(negedge clk); chk("t5_gnt", m0_gnt, 1);
        step(); m0_req = 1'b0; rst = 1'b1;
        @(negedge clk); chk("t5_load", ram_load, 1);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t5_rvalid", m0_rvalid, 0); chk("t5_rdata", m0_rdata, 0);
        chk("t5_m1_rvalid", m1_rvalid, 0); chk("t5_load_off", ram_load, 0);
        chk("t5_store_off", ram_store, 0); chk("t5_addr", ram_address, 0);
        chk("t5_din", ram_data_input, 0); chk("t5_gnts", {m1_gnt, m0_gnt}, 0);
        step();
        @(negedge clk); chk("t5_rvalid_late", m0_rvalid, 0);
        step();
        set_req(0, 1'b1, '{we: 1'b1, addr: 12'h040, wdata: 32'h11112222});
        set_req(1, 1'b1, '{we: 1'b1, addr: 12'h050, wdata: 32'h33334444});
        @(negedge clk); chk("t5_next_m0", m0_gnt, 1); chk("t5_next_m1", m1_gnt, 0);
        step(); m0_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (m1_gnt) ok = 1'b1;
            step();
        end
        m1_req = 1'b0;
        chk("t5_m1_served", ok, 1);
        repeat (3) step();

        // 6: random mixed traffic from both ports
        base = model_grants;
        fork
            begin
                mem_req_t q;
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 3)) step();
                    q.we = 1'($urandom_range(0, 1));
                    q.addr = 12'($urandom_range(0, 15));
                    q.wdata = $urandom;
                    issue(0, q);
                end
            end
            begin
                mem_req_t q;
                for (int n = 0; n < 100; n++) begin
                    repeat ($urandom_range(0, 3)) step();
                    q.we = 1'($urandom_range(0, 1));
                    q.addr = 12'($urandom_range(0, 15));
                    q.wdata = $urandom;
                    issue(1, q);
                end
            end
        join
        repeat (5) step();
        chk("random_grant_count", model_grants - base, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
